// File: rtl/conv2d_engine_if.sv
// Memory read ports and result stream of the conv2d engine.
// Read ports: data for the address driven in cycle t is returned in cycle t+1.
interface conv2d_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int ACC_W  = 2*DATA_W+6
);
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_data;
   logic [ADDR_W-1:0] ker_addr;
   logic [DATA_W-1:0] ker_data;
   // Result stream: out_valid/out_data/out_row/out_col stay stable until the
   // cycle where out_valid && out_ready, which is the single transfer cycle.
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic [ADDR_W-1:0] out_row;
   logic [ADDR_W-1:0] out_col;

   modport master (
      output src_addr, input src_data,
      output ker_addr, input ker_data,
      output out_valid, input out_ready,
      output out_data, output out_row, output out_col
   );

   modport slave (
      input src_addr, output src_data,
      input ker_addr, output ker_data,
      input out_valid, output out_ready,
      input out_data, input out_row, input out_col
   );
endinterface

// File: rtl/conv2d_engine.sv
// Strided 2-D convolution engine: loads a KxK kernel, then walks the image
// window by window, emitting one signed accumulated result per output pixel.
module conv2d_engine #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10,
   parameter int ACC_W  = 2*DATA_W+6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [2:0]        i_stride,
   input  logic [ADDR_W-1:0] i_src_base,
   input  logic [ADDR_W-1:0] i_ker_base,
   conv2d_engine_if.master   bus,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_dbg_state
);
   localparam int KK = K*K;
   localparam int CW = $clog2(KK+1);
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_KERNEL, MAC, EMIT, DONE} state_t;
   state_t state, state_n;

   logic [CW-1:0]     cnt, ker_idx;
   logic [IW-1:0]     ii, jj, ii_n, jj_n;
   logic [2:0]        stride_q;
   logic [ADDR_W-1:0] src_base_q, ker_base_q, src_addr_q, ker_addr_q;
   logic [ADDR_W-1:0] row_pos, col_pos, out_row_q, out_col_q, s_ext;
   logic [ACC_W-1:0]  acc, prod_ext;
   logic [DATA_W-1:0] ker [KK];
   logic signed [2*DATA_W-1:0] prod;
   logic kk_end, issue_more, last_col, last_row;

   // cnt counts issue cycles; the word arriving in cycle cnt belongs to index cnt-1.
   assign kk_end     = (cnt == CW'(KK));
   assign issue_more = (cnt < CW'(KK-1));
   assign ker_idx    = cnt - CW'(1);
   assign prod       = $signed(bus.src_data) * $signed(ker[ker_idx]);
   assign prod_ext   = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign s_ext      = ADDR_W'(stride_q);
   // A window is the last in its row/column when the next one would not fit.
   assign last_col   = (int'(col_pos) + int'(stride_q) + K) > IMG_W;
   assign last_row   = (int'(row_pos) + int'(stride_q) + K) > IMG_H;

   always_comb begin
      ii_n = ii;
      jj_n = jj + IW'(1);
      if (jj == IW'(K-1)) begin
         jj_n = '0;
         ii_n = ii + IW'(1);
      end
   end

   function automatic logic [ADDR_W-1:0] pix_addr(
      input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] rp,
      input logic [ADDR_W-1:0] cp, input logic [IW-1:0] i, input logic [IW-1:0] j);
      return base + (rp + ADDR_W'(i)) * ADDR_W'(IMG_W) + cp + ADDR_W'(j);
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n       = state;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE:        if (i_start) state_n = LOAD_KERNEL;
         LOAD_KERNEL: begin
            o_busy = 1'b1;
            if (kk_end) state_n = MAC;
         end
         MAC: begin
            o_busy = 1'b1;
            if (kk_end) state_n = EMIT;
         end
         EMIT: begin
            o_busy        = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = (last_col && last_row) ? DONE : MAC;
         end
         DONE: begin
            o_done  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0; ii <= '0; jj <= '0; stride_q <= 3'd1;
         src_base_q <= '0; ker_base_q <= '0; src_addr_q <= '0; ker_addr_q <= '0;
         row_pos <= '0; col_pos <= '0; out_row_q <= '0; out_col_q <= '0; acc <= '0;
      end else begin
         case (state)
            IDLE: if (i_start) begin
               stride_q   <= (i_stride == 3'd0) ? 3'd1 : i_stride;
               src_base_q <= i_src_base;
               ker_base_q <= i_ker_base;
               ker_addr_q <= i_ker_base;
               cnt <= '0; ii <= '0; jj <= '0; acc <= '0;
               row_pos <= '0; col_pos <= '0; out_row_q <= '0; out_col_q <= '0;
            end
            LOAD_KERNEL: begin
               if (kk_end) begin
                  cnt        <= '0;
                  src_addr_q <= src_base_q;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (issue_more) ker_addr_q <= ker_base_q + ADDR_W'(cnt) + ADDR_W'(1);
               end
            end
            MAC: begin
               if (cnt != '0) acc <= acc + prod_ext;
               if (kk_end) cnt <= '0;
               else begin
                  cnt <= cnt + CW'(1);
                  if (issue_more) begin
                     ii <= ii_n;
                     jj <= jj_n;
                     src_addr_q <= pix_addr(src_base_q, row_pos, col_pos, ii_n, jj_n);
                  end
               end
            end
            EMIT: if (bus.out_ready) begin
               acc <= '0; ii <= '0; jj <= '0;
               if (last_col) begin
                  col_pos    <= '0;
                  row_pos    <= row_pos + s_ext;
                  out_col_q  <= '0;
                  out_row_q  <= out_row_q + ADDR_W'(1);
                  src_addr_q <= pix_addr(src_base_q, row_pos + s_ext, '0, '0, '0);
               end else begin
                  col_pos    <= col_pos + s_ext;
                  out_col_q  <= out_col_q + ADDR_W'(1);
                  src_addr_q <= pix_addr(src_base_q, row_pos, col_pos + s_ext, '0, '0);
               end
            end
            default: ;
         endcase
      end
   end

   // Kernel storage survives reset and idle; it is rewritten on every job.
   always_ff @(posedge i_clk) begin
      if (state == LOAD_KERNEL && cnt != '0) ker[ker_idx] <= bus.ker_data;
   end

   assign bus.src_addr = src_addr_q;
   assign bus.ker_addr = ker_addr_q;
   assign bus.out_data = acc;
   assign bus.out_row  = out_row_q;
   assign bus.out_col  = out_col_q;
   assign o_dbg_state  = state;
endmodule

// File: tb/tb_conv2d_engine.sv
// Self-checking bench for conv2d_engine on a 5x5 image with a 3x3 kernel,
// compared against a plain-arithmetic convolution model.
module tb_conv2d_engine;
   localparam int DATA_W = 8;
   localparam int K      = 3;
   localparam int IMG_W  = 5;
   localparam int IMG_H  = 5;
   localparam int ADDR_W = 10;
   localparam int ACC_W  = 2*DATA_W+6;
   localparam int EW     = 2*ADDR_W+ACC_W;
   localparam int MEM_N  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [2:0] stride = 3'd0;
   logic [ADDR_W-1:0] src_base = '0, ker_base = '0;
   logic busy, done;
   logic [2:0] dbg_state;

   conv2d_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

   conv2d_engine #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H),
                   .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stride(stride),
      .i_src_base(src_base), .i_ker_base(ker_base), .bus(bus),
      .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- memories (one-cycle read latency) ----------------
   logic [DATA_W-1:0] src_mem [MEM_N];
   logic [DATA_W-1:0] ker_mem [MEM_N];

   always @(posedge clk) begin
      bus.src_data <= src_mem[bus.src_addr];
      bus.ker_data <= ker_mem[bus.ker_addr];
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_results = 0;
   int n_done = 0;
   int rdy_mode = 0;          // 0 = always ready, 1 = random, 2 = manual_ready
   logic manual_ready = 1'b1;
   logic [ACC_W-1:0] first_data, last_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = manual_ready;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) n_done++;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() != 0) begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("res_row", 64'(bus.out_row), 64'(e[EW-1 -: ADDR_W]));
               check("res_col", 64'(bus.out_col), 64'(e[ACC_W +: ADDR_W]));
               check("res_data", 64'(bus.out_data), 64'(e[ACC_W-1:0]));
            end
            if (n_results == 0) first_data = bus.out_data;
            last_data = bus.out_data;
            n_results++;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic build_expected(input int s, input int sb, input int kb, output int count);
      int eff, ow, oh;
      longint sum;
      logic [63:0] sum_v;
      eff = (s == 0) ? 1 : s;
      ow = (IMG_W - K) / eff + 1;
      oh = (IMG_H - K) / eff + 1;
      count = ow * oh;
      for (int r = 0; r < oh; r++)
         for (int c = 0; c < ow; c++) begin
            sum = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  sum += longint'($signed(src_mem[(sb + (r*eff + i)*IMG_W + c*eff + j) % MEM_N]))
                       * longint'($signed(ker_mem[(kb + i*K + j) % MEM_N]));
            sum_v = sum;
            exp_q.push_back({ADDR_W'(r), ADDR_W'(c), sum_v[ACC_W-1:0]});
         end
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start(input int s, input int sb, input int kb);
      @(posedge clk); #1;
      stride = 3'(s); src_base = ADDR_W'(sb); ker_base = ADDR_W'(kb); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic start_job(input int s, input int sb, input int kb, output int count);
      exp_q.delete();
      n_results = 0;
      n_done = 0;
      build_expected(s, sb, kb, count);
      pulse_start(s, sb, kb);
   endtask

   task automatic finish_job(input string tag, input int count);
      logic seen;
      seen = 1'b0;
      for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      @(negedge clk);
      check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
      check({tag, "_result_count"}, 64'(n_results), 64'(count));
      check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_job(input string tag, input int s, input int sb, input int kb);
      int count;
      start_job(s, sb, kb, count);
      finish_job(tag, count);
   endtask

   task automatic load_ramp(input int sb);
      for (int n = 0; n < IMG_W*IMG_H; n++) src_mem[(sb + n) % MEM_N] = DATA_W'(n + 1);
   endtask

   task automatic fill_kernel(input int kb, input logic [DATA_W-1:0] v);
      for (int n = 0; n < K*K; n++) ker_mem[(kb + n) % MEM_N] = v;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_src_addr"}, 64'(bus.src_addr), 64'd0);
      check({tag, "_ker_addr"}, 64'(bus.ker_addr), 64'd0);
      check({tag, "_data"}, 64'(bus.out_data), 64'd0);
      check({tag, "_row"}, 64'(bus.out_row), 64'd0);
      check({tag, "_col"}, 64'(bus.out_col), 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [ACC_W-1:0] v_data, neg_exp;
      logic [ADDR_W-1:0] v_row, v_col, v_sa, v_ka;
      logic hit;
      int count;

      for (int n = 0; n < MEM_N; n++) begin
         src_mem[n] = '0;
         ker_mem[n] = '0;
      end

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Ramp image 1..25, all-ones kernel, stride 1 then stride 2.
      load_ramp(100);
      fill_kernel(600, 8'd1);
      run_job("s1_ramp", 1, 100, 600);
      check("s1_first", 64'(first_data), 64'd63);
      check("s1_last", 64'(last_data), 64'd171);
      run_job("s2_ramp", 2, 100, 600);
      check("s2_last", 64'(last_data), 64'd171);

      // Negative kernel against a saturated image.
      for (int n = 0; n < IMG_W*IMG_H; n++) src_mem[200 + n] = 8'd127;
      fill_kernel(700, 8'hFF);
      run_job("neg", 1, 200, 700);
      neg_exp = -ACC_W'(1143);
      check("neg_first", 64'(first_data), 64'(neg_exp));
      check("neg_last", 64'(last_data), 64'(neg_exp));

      // Hold the first result for ten cycles of backpressure.
      manual_ready = 1'b0;
      rdy_mode = 2;
      start_job(1, 100, 600, count);
      hit = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         @(negedge clk);
         hit = bus.out_valid;
      end
      check("stall_valid_seen", 64'(hit), 64'd1);
      v_data = bus.out_data; v_row = bus.out_row; v_col = bus.out_col;
      v_sa = bus.src_addr; v_ka = bus.ker_addr;
      check("stall_row0", 64'(v_row), 64'd0);
      check("stall_col0", 64'(v_col), 64'd0);
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         check("stall_valid", 64'(bus.out_valid), 64'd1);
         check("stall_data", 64'(bus.out_data), 64'(v_data));
         check("stall_row", 64'(bus.out_row), 64'(v_row));
         check("stall_col", 64'(bus.out_col), 64'(v_col));
         check("stall_src_addr", 64'(bus.src_addr), 64'(v_sa));
         check("stall_ker_addr", 64'(bus.ker_addr), 64'(v_ka));
      end
      manual_ready = 1'b1;
      finish_job("stall", count);
      rdy_mode = 0;

      // Abort while computing output (1,1), then rerun cleanly.
      start_job(1, 100, 600, count);
      hit = 1'b0;
      for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
         @(negedge clk);
         hit = busy && !bus.out_valid && bus.out_row == ADDR_W'(1) && bus.out_col == ADDR_W'(1);
      end
      check("abort_point_seen", 64'(hit), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("abort");
      repeat (3) @(negedge clk);
      check("abort_no_done", 64'(n_done), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_job("after_abort", 1, 100, 600);
      check("after_abort_first", 64'(first_data), 64'd63);

      // Stride 0 behaves as stride 1; a start while busy must change nothing.
      start_job(0, 100, 600, count);
      repeat (15) @(posedge clk);
      pulse_start(2, 300, 800);
      finish_job("stride0_busy_start", count);
      check("stride0_last", 64'(last_data), 64'd171);

      // Random contents, strides, bases (including wrap) and backpressure.
      rdy_mode = 1;
      for (int t = 0; t < 4; t++) begin
         int sb, kb;
         sb = $urandom_range(0, MEM_N-1);
         kb = $urandom_range(0, MEM_N-1);
         for (int n = 0; n < MEM_N; n++) begin
            src_mem[n] = DATA_W'($urandom);
            ker_mem[n] = DATA_W'($urandom);
         end
         run_job("random", $urandom_range(0, 3), sb, kb);
      end
      rdy_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
